// File: rtl/aes_round_core_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, computed S-boxes and the four
// 128-bit state transforms used by the iterative round datapath.
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam logic [7:0] AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } core_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // b^254 by square-and-multiply; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] s;
    x = gf_inv(b);
    for (int i = 0; i < 8; i++) begin
      s[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8]
             ^ x[(i + 7) % 8] ^ AFFINE_C[i];
    end
    return s;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x;
    for (int i = 0; i < 8; i++) begin
      x[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ INV_AFFINE_C[i];
    end
    return gf_inv(x);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8 * k -: 8] = sbox(s[127 - 8 * k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
    end
    return o;
  endfunction

  // byte k sits at row k%4, column k/4
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // MSB position of round key idx in a schedule of nr+1 keys, key 0 on top
  function automatic int rk_msb(input int nr, input int idx);
    return (nr + 1) * BLOCK_W - 1 - idx * BLOCK_W;
  endfunction

endpackage

// File: rtl/aes_round_core_if.sv
// Block-level handshake between the key-schedule/driver side and one round core.
interface aes_round_core_if
  import aes_pkg::*;
#(
  parameter int NR = 10
);
  logic                        start;
  logic [BLOCK_W-1:0]          in;
  logic [(NR+1)*BLOCK_W-1:0]   w;
  logic [BLOCK_W-1:0]          out;
  logic                        busy;
  logic                        done;

  modport master (output start, output in, output w, input out, input busy, input done);
  modport slave  (input start, input in, input w, output out, output busy, output done);
endinterface

// File: rtl/aes_round_core_round.sv
// One full AES round (forward or inverse), purely combinational.
module aes_round
  import aes_pkg::*;
#(
  parameter int DECRYPT = 0
) (
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rk,
  input  logic               last,
  output logic [BLOCK_W-1:0] nxt
);

  logic [BLOCK_W-1:0] mid_s;

  // inverse round mixes after the key add, forward round before it
  always_comb begin
    mid_s = '0;
    nxt   = '0;
    if (DECRYPT != 0) begin
      mid_s = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
      if (last) begin
        nxt = mid_s;
      end else begin
        nxt = inv_mix_columns(mid_s);
      end
    end else begin
      mid_s = shift_rows(sub_bytes(state));
      if (last) begin
        nxt = mid_s ^ rk;
      end else begin
        nxt = mix_columns(mid_s) ^ rk;
      end
    end
  end

endmodule

// File: rtl/aes_round_core.sv
// Iterative AES cipher/inverse cipher: initial key add on start, then one
// round per clock until round NR, with a registered result and done pulse.
module aes_round_core
  import aes_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int NR      = 10,
  parameter int NK      = 4,
  parameter int DECRYPT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_round_core_if.slave bus
);

  generate
    if (DATA_W != BLOCK_W) begin : g_bad_width
      $error("aes_round_core: DATA_W must be 128");
    end
    if ((NR != 10 && NR != 12 && NR != 14) || NK != NR - 6) begin : g_bad_rounds
      $error("aes_round_core: NR must be 10/12/14 and NK must equal NR-6");
    end
  endgenerate

  localparam logic [3:0] NR_4     = 4'(NR);
  localparam int         LOAD_IDX = (DECRYPT != 0) ? NR : 0;

  logic [BLOCK_W-1:0] rk [0:NR];
  logic [BLOCK_W-1:0] state_r;
  logic [BLOCK_W-1:0] out_r;
  logic [3:0]         round_r;
  logic               done_r;
  core_state_e        fsm_r;

  logic [3:0]         rk_idx_s;
  logic [BLOCK_W-1:0] rk_sel_s;
  logic               last_s;
  logic [BLOCK_W-1:0] round_out_s;

  for (genvar i = 0; i <= NR; i++) begin : g_rk
    assign rk[i] = bus.w[rk_msb(NR, i) -: BLOCK_W];
  end

  // inverse cipher walks the schedule from the top down
  always_comb begin
    rk_idx_s = 4'd0;
    if (DECRYPT != 0) begin
      rk_idx_s = NR_4 - round_r;
    end else begin
      rk_idx_s = round_r;
    end
    rk_sel_s = rk[rk_idx_s];
    last_s   = (round_r == NR_4);
  end

  aes_round #(
    .DECRYPT (DECRYPT)
  ) u_round (
    .state (state_r),
    .rk    (rk_sel_s),
    .last  (last_s),
    .nxt   (round_out_s)
  );

  // control FSM, round counter, state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r   <= ST_IDLE;
      state_r <= '0;
      out_r   <= '0;
      round_r <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= bus.in ^ rk[LOAD_IDX];
            round_r <= 4'd1;
            fsm_r   <= ST_RUN;
          end else begin
            round_r <= 4'd0;
          end
        end
        ST_RUN: begin
          state_r <= round_out_s;
          if (last_s) begin
            out_r   <= round_out_s;
            done_r  <= 1'b1;
            round_r <= 4'd0;
            fsm_r   <= ST_IDLE;
          end else begin
            done_r  <= 1'b0;
            round_r <= round_r + 4'd1;
          end
        end
        default: begin
          fsm_r   <= ST_IDLE;
          round_r <= 4'd0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.busy = (fsm_r == ST_RUN);
  assign bus.done = done_r;

endmodule

// File: tb/tb_aes_round_core.sv
// Directed bench for six aes_round_core instances (AES-128/192/256, both
// directions) using the FIPS-197 known-answer vectors.
module tb_aes_round_core;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT1  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_a [6];
  logic [127:0] in_a    [6];
  logic [127:0] out_a   [6];
  logic         busy_a  [6];
  logic         done_a  [6];
  logic [127:0] ref_in  [6];
  logic [127:0] ref_out [6];
  int           nr_a    [6];

  logic [1407:0] w_e128;
  logic [1407:0] w128;
  logic [1407:0] w128_b;
  logic [1663:0] w192;
  logic [1919:0] w256;

  int n_checks = 0;
  int n_fail   = 0;

  aes_round_core_if #(.NR(10)) e128_if ();
  aes_round_core_if #(.NR(12)) e192_if ();
  aes_round_core_if #(.NR(14)) e256_if ();
  aes_round_core_if #(.NR(10)) d128_if ();
  aes_round_core_if #(.NR(12)) d192_if ();
  aes_round_core_if #(.NR(14)) d256_if ();

  assign e128_if.start = start_a[0]; assign e128_if.in = in_a[0]; assign e128_if.w = w_e128;
  assign e192_if.start = start_a[1]; assign e192_if.in = in_a[1]; assign e192_if.w = w192;
  assign e256_if.start = start_a[2]; assign e256_if.in = in_a[2]; assign e256_if.w = w256;
  assign d128_if.start = start_a[3]; assign d128_if.in = in_a[3]; assign d128_if.w = w128;
  assign d192_if.start = start_a[4]; assign d192_if.in = in_a[4]; assign d192_if.w = w192;
  assign d256_if.start = start_a[5]; assign d256_if.in = in_a[5]; assign d256_if.w = w256;

  assign out_a[0] = e128_if.out; assign busy_a[0] = e128_if.busy; assign done_a[0] = e128_if.done;
  assign out_a[1] = e192_if.out; assign busy_a[1] = e192_if.busy; assign done_a[1] = e192_if.done;
  assign out_a[2] = e256_if.out; assign busy_a[2] = e256_if.busy; assign done_a[2] = e256_if.done;
  assign out_a[3] = d128_if.out; assign busy_a[3] = d128_if.busy; assign done_a[3] = d128_if.done;
  assign out_a[4] = d192_if.out; assign busy_a[4] = d192_if.busy; assign done_a[4] = d192_if.done;
  assign out_a[5] = d256_if.out; assign busy_a[5] = d256_if.busy; assign done_a[5] = d256_if.done;

  aes_round_core #(.NR(10), .NK(4), .DECRYPT(0)) u_e128 (.clk(clk), .rst_n(rst_n), .bus(e128_if));
  aes_round_core #(.NR(12), .NK(6), .DECRYPT(0)) u_e192 (.clk(clk), .rst_n(rst_n), .bus(e192_if));
  aes_round_core #(.NR(14), .NK(8), .DECRYPT(0)) u_e256 (.clk(clk), .rst_n(rst_n), .bus(e256_if));
  aes_round_core #(.NR(10), .NK(4), .DECRYPT(1)) u_d128 (.clk(clk), .rst_n(rst_n), .bus(d128_if));
  aes_round_core #(.NR(12), .NK(6), .DECRYPT(1)) u_d192 (.clk(clk), .rst_n(rst_n), .bus(d192_if));
  aes_round_core #(.NR(14), .NK(8), .DECRYPT(1)) u_d256 (.clk(clk), .rst_n(rst_n), .bus(d256_if));

  function automatic logic [7:0] b_sbox(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX_TBL[2047 - 8 * idx -: 8];
  endfunction

  function automatic logic [31:0] b_subw(input logic [31:0] x);
    return {b_sbox(x[31:24]), b_sbox(x[23:16]), b_sbox(x[15:8]), b_sbox(x[7:0])};
  endfunction

  // FIPS-197 key expansion, schedule right-aligned with word 0 on top
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      t = wd[i - 1];
      if (i % nk == 0) begin
        t  = b_subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = b_subw(t);
      end
      wd[i] = wd[i - nk] ^ t;
    end
    for (int i = 0; i < total; i++) res[total * 32 - 1 - 32 * i -: 32] = wd[i];
    return res;
  endfunction

  task automatic start_block(input int d, input logic [127:0] din);
    @(negedge clk);
    in_a[d] = din;
    start_a[d] = 1'b1;
    @(posedge clk);
    #1;
    start_a[d] = 1'b0;
  endtask

  // cycles from the start edge until done is seen, -1 if it never comes
  task automatic wait_done(input int d, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done_a[d]) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    for (int d = 0; d < 6; d++) begin
      n_checks += 3;
      if (out_a[d] !== 128'h0) begin
        n_fail++; $display("FAIL reset_out[%0d]: got %h expected 0", d, out_a[d]);
      end
      if (busy_a[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_a[d]);
      end
      if (done_a[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_done[%0d]: got %b expected 0", d, done_a[d]);
      end
    end
  endtask

  task automatic run_kat(input int first);
    int cyc;
    for (int d = first; d < first + 3; d++) begin
      start_block(d, ref_in[d]);
      n_checks++;
      if (busy_a[d] !== 1'b1) begin
        n_fail++; $display("FAIL kat_busy[%0d]: got %b expected 1", d, busy_a[d]);
      end
      wait_done(d, cyc);
      n_checks += 2;
      if (cyc !== nr_a[d]) begin
        n_fail++; $display("FAIL kat_latency[%0d]: got %0d expected %0d", d, cyc, nr_a[d]);
      end
      if (out_a[d] !== ref_out[d]) begin
        n_fail++; $display("FAIL kat_out[%0d]: got %h expected %h", d, out_a[d], ref_out[d]);
      end
      @(posedge clk);
      #1;
      n_checks += 3;
      if (done_a[d] !== 1'b0) begin
        n_fail++; $display("FAIL kat_done_pulse[%0d]: got %b expected 0", d, done_a[d]);
      end
      if (busy_a[d] !== 1'b0) begin
        n_fail++; $display("FAIL kat_idle[%0d]: got %b expected 0", d, busy_a[d]);
      end
      if (out_a[d] !== ref_out[d]) begin
        n_fail++; $display("FAIL kat_hold[%0d]: got %h expected %h", d, out_a[d], ref_out[d]);
      end
    end
  endtask

  task automatic test_encrypt;
    run_kat(0);
  endtask

  task automatic test_decrypt;
    run_kat(3);
  endtask

  task automatic test_start_ignored;
    int hits;
    int hit_cyc;
    hits = 0;
    hit_cyc = 0;
    start_block(0, PT);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 3 || c == 7) begin
        start_a[0] = 1'b1;
        in_a[0] = 128'hdeadbeef_01234567_89abcdef_cafef00d;
      end else begin
        start_a[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_a[0]) begin
        hits++;
        hit_cyc = c;
      end
    end
    start_a[0] = 1'b0;
    n_checks += 3;
    if (hits !== 1) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", hits);
    end
    if (hit_cyc !== 10) begin
      n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 10", hit_cyc);
    end
    if (out_a[0] !== CT0) begin
      n_fail++; $display("FAIL ignore_out: got %h expected %h", out_a[0], CT0);
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    int cyc;
    stray = 0;
    start_block(0, PT);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (out_a[0] !== 128'h0) begin
      n_fail++; $display("FAIL midrst_out: got %h expected 0", out_a[0]);
    end
    if (busy_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a[0]);
    end
    if (done_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done: got %b expected 0", done_a[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done_a[0] || busy_a[0]) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", stray);
    end
    start_block(0, PT);
    wait_done(0, cyc);
    n_checks += 2;
    if (cyc !== 10) begin
      n_fail++; $display("FAIL midrst_latency: got %0d expected 10", cyc);
    end
    if (out_a[0] !== CT0) begin
      n_fail++; $display("FAIL midrst_out_after: got %h expected %h", out_a[0], CT0);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int early;
    int changed;
    early = 0;
    changed = 0;
    start_block(0, PT);
    wait_done(0, cyc);
    n_checks++;
    if (out_a[0] !== CT0) begin
      n_fail++; $display("FAIL b2b_first: got %h expected %h", out_a[0], CT0);
    end
    // second block uses a different key, loaded in the done cycle
    w_e128 = w128_b;
    start_block(0, PT_B);
    n_checks++;
    if (busy_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got %b expected 1", busy_a[0]);
    end
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      if (done_a[0]) early++;
      if (out_a[0] !== CT0) changed++;
    end
    n_checks += 2;
    if (early !== 0) begin
      n_fail++; $display("FAIL b2b_early_done: got %0d expected 0", early);
    end
    if (changed !== 0) begin
      n_fail++; $display("FAIL b2b_out_held: got %0d changed cycles expected 0", changed);
    end
    @(posedge clk);
    #1;
    n_checks += 2;
    if (done_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: got %b expected 1", done_a[0]);
    end
    if (out_a[0] !== CT_B) begin
      n_fail++; $display("FAIL b2b_second: got %h expected %h", out_a[0], CT_B);
    end
  endtask

  initial begin
    logic [1919:0] tmp;
    for (int d = 0; d < 6; d++) begin
      start_a[d] = 1'b0;
      in_a[d] = '0;
    end
    tmp = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    w128 = tmp[1407:0];
    tmp = expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    w128_b = tmp[1407:0];
    tmp = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
    w192 = tmp[1663:0];
    tmp = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    w256 = tmp;
    w_e128 = w128;
    nr_a[0] = 10; nr_a[1] = 12; nr_a[2] = 14;
    nr_a[3] = 10; nr_a[4] = 12; nr_a[5] = 14;
    ref_in[0] = PT;  ref_in[1] = PT;  ref_in[2] = PT;
    ref_out[0] = CT0; ref_out[1] = CT1; ref_out[2] = CT2;
    ref_in[3] = CT0; ref_in[4] = CT1; ref_in[5] = CT2;
    ref_out[3] = PT; ref_out[4] = PT; ref_out[5] = PT;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_encrypt();
    test_decrypt();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
